// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master (width, CPOL/CPHA, bit order, slave selects).
// Define SPI_IRQ_EN to add the irq output and the CTRL bit6 irq_en enable.
module spi_master_param #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned CS_NUM = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              wr,
  input  logic              rd,
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [CS_NUM-1:0] ss_n
`ifdef SPI_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int unsigned      EdgeW    = $clog2(2 * DATA_W);
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W - 1);

  typedef enum logic [1:0] {StIdle, StSetup, StXfer, StHold} state_e;

  state_e            state;
  logic [DIV_W-1:0]  clk_div;
  logic [DIV_W-1:0]  div_cnt;
  logic [EdgeW-1:0]  edge_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] rx_data;
  logic              sclk_buf;
  logic              busy;
  logic              done;
  logic              collision;
  logic              cpol;
  logic              cpha;
  logic              lsb_first;
  logic [2:0]        ss_sel;
  logic              irq_en_rd;
  logic [CS_NUM-1:0] ss_dec;
  logic              half_end;
  logic              leading;
  logic              wr_data;
  logic              wr_status;
  logic              wr_div;
  logic              wr_ctrl;
  logic              rd_data;
`ifdef SPI_IRQ_EN
  logic              irq_en;
  assign irq_en_rd = irq_en;
`else
  assign irq_en_rd = 1'b0;
`endif

  assign sclk      = sclk_buf;
  assign wr_data   = cs && wr && (addr == 2'd0);
  assign wr_status = cs && wr && (addr == 2'd1);
  assign wr_div    = cs && wr && (addr == 2'd2);
  assign wr_ctrl   = cs && wr && (addr == 2'd3);
  assign rd_data   = cs && rd && (addr == 2'd0);
  assign half_end  = (div_cnt == clk_div);
  // Even edge indices are leading edges (away from the idle level).
  assign leading   = ~edge_cnt[0];

  function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_tx(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? {1'b0, v[DATA_W-1:1]} : {v[DATA_W-2:0], 1'b0};
  endfunction

  // Out-of-range ss_sel leaves every select deasserted.
  always_comb begin
    ss_dec = '1;
    for (int i = 0; i < CS_NUM; i++) begin
      if (ss_sel == 3'(i)) ss_dec[i] = 1'b0;
    end
  end

  always_comb begin
    out_data = '0;
    if (cs && rd) begin
      case (addr)
        2'd0:    out_data = rx_data;
        2'd1:    out_data = DATA_W'({collision, done, busy});
        2'd2:    out_data = DATA_W'(clk_div);
        default: out_data = DATA_W'({irq_en_rd, ss_sel, lsb_first, cpha, cpol});
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= StIdle;
      sclk_buf  <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
      busy      <= 1'b0;
      done      <= 1'b0;
      collision <= 1'b0;
      rx_data   <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
      clk_div   <= '0;
      div_cnt   <= '0;
      edge_cnt  <= '0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      lsb_first <= 1'b0;
      ss_sel    <= '0;
`ifdef SPI_IRQ_EN
      irq_en    <= 1'b0;
      irq       <= 1'b0;
`endif
    end else begin
      if (rd_data) done <= 1'b0;
      if (wr_status && in_data[2]) collision <= 1'b0;
      if (busy && (wr_data || wr_div || wr_ctrl)) collision <= 1'b1;
      if (!busy && wr_div) clk_div <= DIV_W'(in_data);
      if (!busy && wr_ctrl) begin
        cpol      <= in_data[0];
        cpha      <= in_data[1];
        lsb_first <= in_data[2];
        ss_sel    <= in_data[5:3];
`ifdef SPI_IRQ_EN
        irq_en    <= in_data[6];
`endif
      end

      unique case (state)
        StIdle: begin
          sclk_buf <= wr_ctrl ? in_data[0] : cpol;
          if (wr_data) begin
            state   <= StSetup;
            busy    <= 1'b1;
            div_cnt <= '0;
            ss_n    <= ss_dec;
            // cpha=0 presents the first bit during setup; cpha=1 waits for the first leading edge.
            if (cpha) begin
              tx_shift <= in_data;
            end else begin
              mosi     <= first_bit(in_data, lsb_first);
              tx_shift <= shift_tx(in_data, lsb_first);
            end
          end
        end
        StSetup: begin
          if (half_end) begin
            state    <= StXfer;
            div_cnt  <= '0;
            edge_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        StXfer: begin
          if (half_end) begin
            div_cnt  <= '0;
            sclk_buf <= ~sclk_buf;
            edge_cnt <= edge_cnt + EdgeW'(1);
            if (leading != cpha) begin
              rx_shift <= lsb_first ? {miso, rx_shift[DATA_W-1:1]}
                                    : {rx_shift[DATA_W-2:0], miso};
            end else if (cpha || edge_cnt != LastEdge) begin
              mosi     <= first_bit(tx_shift, lsb_first);
              tx_shift <= shift_tx(tx_shift, lsb_first);
            end
            if (edge_cnt == LastEdge) state <= StHold;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        StHold: begin
          if (half_end) begin
            state   <= StIdle;
            div_cnt <= '0;
            ss_n    <= '1;
            rx_data <= rx_shift;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        default: state <= StIdle;
      endcase

`ifdef SPI_IRQ_EN
      irq <= irq_en & (done | collision);
`endif
    end
  end

endmodule

// File: tb/tb_spi_master_param.sv
// Self-checking bench for spi_master_param: directed and random transfers against an SPI slave
// model and word-level expectations (bit order, edge timing, busy length, status flags).
`timescale 1ns/1ps
module tb_spi_master_param;
  localparam int DW  = 8;
  localparam int CSN = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           cs = 1'b0;
  logic           wr = 1'b0;
  logic           rd = 1'b0;
  logic [1:0]     addr = 2'd0;
  logic [DW-1:0]  in_data = '0;
  logic [DW-1:0]  out_data;
  logic           sclk;
  logic           mosi;
  logic           miso;
  logic [CSN-1:0] ss_n;
`ifdef SPI_IRQ_EN
  logic           irq;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_master_param #(.DATA_W(DW), .DIV_W(8), .CS_NUM(CSN)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .wr(wr), .rd(rd), .addr(addr), .in_data(in_data),
    .out_data(out_data), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
`ifdef SPI_IRQ_EN
    , .irq(irq)
`endif
  );

  // Slave model: follows sclk edges only, sends slv_tx in the configured order.
  logic           slv_on = 1'b0;
  logic           s_cpol = 1'b0;
  logic           s_cpha = 1'b0;
  logic           s_lsb = 1'b0;
  logic [7:0]     slv_tx = 8'h00;
  int             slv_idx;
  int             rises;
  int             mosi_bad;
  int             cyc = 0;
  logic           lead_seen;
  logic           sclk_prev;
  logic           mosi_prev;
  logic [CSN-1:0] ss_seen;
  int             edge_q[$];
  logic           mosi_q[$];
  logic [2:0]     mi;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    mi   = (slv_idx > 7) ? 3'd7 : 3'(slv_idx);
    miso = s_lsb ? slv_tx[mi] : slv_tx[3'd7 - mi];
  end

  always @(negedge clk) begin
    if (!slv_on) begin
      slv_idx   = 0;
      rises     = 0;
      mosi_bad  = 0;
      lead_seen = 1'b0;
      ss_seen   = '0;
      edge_q.delete();
      mosi_q.delete();
    end else begin
      if (sclk !== sclk_prev) begin
        edge_q.push_back(cyc);
        if (sclk === 1'b1) rises++;
        if ((sclk !== s_cpol) != s_cpha) mosi_q.push_back(mosi);
        if (sclk === s_cpol && !s_cpha) slv_idx++;
        if (sclk !== s_cpol && s_cpha) begin
          if (lead_seen) slv_idx++;
          lead_seen = 1'b1;
        end
      end
      if (mosi !== mosi_prev && !(sclk_prev === 1'b1 && sclk === 1'b0)) mosi_bad++;
      ss_seen |= ~ss_n;
    end
    sclk_prev = sclk;
    mosi_prev = mosi;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; in_data = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; in_data = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
    cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
    #1 d = out_data;
    @(posedge clk); #1;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic xfer(input string tag, input logic [7:0] tx, input logic [7:0] stx,
                      input logic [7:0] div, input logic [7:0] ctrl, input int coll_at);
    int             cyc_w, n, bad, h;
    logic [7:0]     seq, eseq, d;
    logic           coll;
    logic [2:0]     ssel;
    logic [CSN-1:0] exp_ss;
    h      = int'(div) + 1;
    ssel   = ctrl[5:3];
    exp_ss = (ssel < CSN) ? CSN'(1 << ssel) : '0;
    bus_write(2'd2, div);
    bus_write(2'd3, ctrl);
    chk({tag, " sclk_idle"}, 32'(sclk), 32'(ctrl[0]));
    slv_on = 1'b0;
    @(posedge clk); #1;
    s_cpol = ctrl[0]; s_cpha = ctrl[1]; s_lsb = ctrl[2]; slv_tx = stx; slv_on = 1'b1;
    bus_write(2'd0, tx);
    cyc_w = cyc;
    cs = 1'b1; rd = 1'b1; addr = 2'd1; #1;
    n = 0; coll = 1'b0;
    while (out_data[0] === 1'b1 && n < 2000) begin
      if (n == coll_at) begin
        rd = 1'b0; wr = 1'b1; addr = 2'd0; in_data = ~tx;
        @(posedge clk); #1;
        wr = 1'b0; rd = 1'b1; addr = 2'd1; in_data = '0; #1;
        coll = 1'b1;
        chk({tag, " status_coll"}, 32'(out_data), 32'h5);
      end else begin
        @(posedge clk); #2;
      end
      n++;
    end
    chk({tag, " busy_len"}, 32'(cyc - cyc_w), 32'((2 * DW + 2) * h));
    chk({tag, " status_done"}, 32'(out_data), 32'({coll, 2'b10}));
    cs = 1'b0; rd = 1'b0;
    chk({tag, " edges"}, 32'(edge_q.size()), 32'(2 * DW));
    chk({tag, " rises"}, 32'(rises), 32'(DW));
    chk({tag, " first_edge"}, (edge_q.size() > 0) ? 32'(edge_q[0] - cyc_w) : 32'hFFFF, 32'(2 * h));
    bad = 0;
    for (int i = 1; i < edge_q.size(); i++) if (edge_q[i] - edge_q[i-1] != h) bad++;
    chk({tag, " half_period"}, 32'(bad), 32'h0);
    seq = '0; eseq = '0;
    for (int i = 0; i < 8; i++) begin
      eseq[7-i] = ctrl[2] ? tx[i] : tx[7-i];
      if (i < mosi_q.size()) seq[7-i] = mosi_q[i];
    end
    chk({tag, " mosi_count"}, 32'(mosi_q.size()), 32'(DW));
    chk({tag, " mosi_bits"}, 32'(seq), 32'(eseq));
    if (ctrl[1:0] == 2'b11) chk({tag, " mosi_on_fall"}, 32'(mosi_bad), 32'h0);
    chk({tag, " ss_seen"}, 32'(ss_seen), 32'(exp_ss));
    chk({tag, " ss_release"}, 32'(ss_n), 32'({CSN{1'b1}}));
    bus_read(2'd0, d);
    chk({tag, " rx"}, 32'(d), 32'(stx));
    bus_read(2'd1, d);
    chk({tag, " status_cleared"}, 32'(d), 32'({coll, 2'b00}));
    if (coll) begin
      bus_write(2'd1, 8'h04);
      bus_read(2'd1, d);
      chk({tag, " coll_clear"}, 32'(d), 32'h0);
    end
  endtask

  initial begin
    logic [7:0] d;
    int         n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst sclk", 32'(sclk), 32'h0);
    chk("rst mosi", 32'(mosi), 32'h0);
    chk("rst ss_n", 32'(ss_n), 32'hF);
    bus_read(2'd1, d); chk("rst status", 32'(d), 32'h0);
    bus_read(2'd2, d); chk("rst div", 32'(d), 32'h0);
    bus_read(2'd3, d); chk("rst ctrl", 32'(d), 32'h0);
    bus_read(2'd0, d); chk("rst data", 32'(d), 32'h0);

    xfer("mode0", 8'hA5, 8'h3C, 8'd0, 8'h00, -1);
    cs = 1'b1; rd = 1'b0; addr = 2'd0; #1;
    chk("no_rd gate", 32'(out_data), 32'h0);
    cs = 1'b0; rd = 1'b1; #1;
    chk("no_cs gate", 32'(out_data), 32'h0);
    rd = 1'b0;

    xfer("mode3", 8'h81, 8'($urandom), 8'd3, 8'h03, -1);
    xfer("lsb", 8'h01, 8'h80, 8'd0, 8'h04, -1);
    xfer("coll", 8'($urandom), 8'($urandom), 8'd0, 8'h00, 4);
    xfer("ss2", 8'($urandom), 8'($urandom), 8'd1, 8'h10, -1);
    xfer("ss5", 8'($urandom), 8'($urandom), 8'd0, 8'h28, -1);
    for (int k = 0; k < 4; k++) begin
      xfer($sformatf("rand%0d", k), 8'($urandom), 8'($urandom), 8'($urandom_range(0, 3)),
           {2'b00, 3'($urandom_range(0, 7)), 3'($urandom)}, -1);
    end

    // Asynchronous reset in the middle of a transfer.
    bus_write(2'd2, 8'd1);
    bus_write(2'd3, 8'h0C);
    bus_write(2'd0, 8'h5A);
    repeat (8) @(posedge clk);
    #1 chk("mid ss_n", 32'(ss_n), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("arst sclk", 32'(sclk), 32'h0);
    chk("arst ss_n", 32'(ss_n), 32'hF);
    chk("arst mosi", 32'(mosi), 32'h0);
    cs = 1'b1; rd = 1'b1; addr = 2'd1; #1;
    chk("arst status", 32'(out_data), 32'h0);
    cs = 1'b0; rd = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    bus_read(2'd2, d); chk("arst div", 32'(d), 32'h0);
    bus_read(2'd3, d); chk("arst ctrl", 32'(d), 32'h0);
    bus_read(2'd0, d); chk("arst data", 32'(d), 32'h0);
    repeat (3) @(posedge clk);
    #1 chk("arst idle ss_n", 32'(ss_n), 32'hF);

    bus_write(2'd3, 8'h40);
    bus_read(2'd3, d);
`ifdef SPI_IRQ_EN
    chk("ctrl irq_en", 32'(d), 32'h40);
    chk("irq idle", 32'(irq), 32'h0);
    bus_write(2'd0, 8'h33);
    cs = 1'b1; rd = 1'b1; addr = 2'd1; #1;
    n = 0;
    while (out_data[1] !== 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("irq done seen", 32'(out_data[1]), 32'h1);
    chk("irq at done", 32'(irq), 32'h0);
    @(posedge clk); #1;
    chk("irq after done", 32'(irq), 32'h1);
    bus_read(2'd0, d);
    chk("irq at read", 32'(irq), 32'h1);
    @(posedge clk); #1;
    chk("irq after read", 32'(irq), 32'h0);
`else
    chk("ctrl bit6", 32'(d), 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
